// File: rtl/apb_timer_slave_pkg.sv
// Shared definitions for the APB timer slave: register offsets, bit indices, phase FSM states.
package apb_timer_slave_pkg;

  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_LOAD   = 2'd1;
  localparam logic [1:0] TMR_VALUE  = 2'd2;
  localparam logic [1:0] TMR_STATUS = 2'd3;

  localparam int unsigned CTRL_EN        = 0;
  localparam int unsigned CTRL_PERIODIC  = 1;
  localparam int unsigned CTRL_IE        = 2;
  localparam int unsigned CTRL_PRESC_LSB = 8;
  localparam int unsigned CTRL_PRESC_MSB = 15;

  localparam int unsigned STATUS_TF   = 0;
  localparam int unsigned STATUS_PERR = 1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } apb_state_e;

  function automatic logic [31:0] status_word(input logic tf, input logic perr);
    logic [31:0] w;
    w              = 32'd0;
    w[STATUS_TF]   = tf;
    w[STATUS_PERR] = perr;
    return w;
  endfunction

endpackage

// File: rtl/apb_slave_if.sv
// APB phase tracker: IDLE/SETUP/ACCESS sequencing, write/read strobes and protocol-error detect.
module apb_slave_if
  import apb_timer_slave_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       psel_i,
  input  logic       penable_i,
  input  logic       pwrite_i,
  input  logic [1:0] paddr_i,
  output logic       wr_en_o,
  output logic       rd_en_o,
  output logic [1:0] reg_sel_o,
  output logic       perr_pulse_o
);

  apb_state_e state_q;

  // An enable strobe is only legal directly after a setup phase.
  always_comb begin
    perr_pulse_o = psel_i & penable_i & (state_q != StSetup);
    wr_en_o      = psel_i & penable_i & pwrite_i & (state_q == StSetup);
    rd_en_o      = psel_i & ~penable_i & ~pwrite_i;
    reg_sel_o    = paddr_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (psel_i && !penable_i) state_q <= StSetup;
        end
        StSetup: begin
          if (!psel_i) begin
            state_q <= StIdle;
          end else if (penable_i) begin
            state_q <= StAccess;
          end
        end
        StAccess: begin
          state_q <= (psel_i && !penable_i) ? StSetup : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/apb_timer_slave.sv
// Zero-wait-state APB timer: down-counter with one-shot/periodic reload and level IRQ.
// Optional prescaler (CTRL[15:8]) is built when APB_TIMER_PRESCALER_EN is defined.
module apb_timer_slave
  import apb_timer_slave_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter logic [31:0] RST_LOAD = 32'd0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        IRQ
);

  logic             wr_en, rd_en, perr_pulse;
  logic [1:0]       reg_sel;
  logic             wr_ctrl, wr_load, wr_status;
  logic             tick, fire;
  logic [7:0]       presc_rd;
  logic [31:0]      rd_mux;

  logic             en_q, en_d;
  logic             periodic_q, periodic_d;
  logic             ie_q, ie_d;
  logic             tf_q, tf_d;
  logic             perr_q, perr_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] value_q, value_d;

  logic unused_paddr;
  assign unused_paddr = ^{PADDR[31:4], PADDR[1:0]};

  apb_slave_if u_apb_slave_if (
    .clk_i        (HCLK),
    .rst_ni       (HRESETn),
    .psel_i       (PSEL),
    .penable_i    (PENABLE),
    .pwrite_i     (PWRITE),
    .paddr_i      (PADDR[3:2]),
    .wr_en_o      (wr_en),
    .rd_en_o      (rd_en),
    .reg_sel_o    (reg_sel),
    .perr_pulse_o (perr_pulse)
  );

  assign wr_ctrl   = wr_en && (reg_sel == TMR_CTRL);
  assign wr_load   = wr_en && (reg_sel == TMR_LOAD);
  assign wr_status = wr_en && (reg_sel == TMR_STATUS);

`ifdef APB_TIMER_PRESCALER_EN
  logic [7:0] presc_q, presc_d;
  logic [7:0] pcnt_q, pcnt_d;

  // Tick on the last cycle of each PRESC+1 window; a CTRL write restarts the window.
  assign tick     = en_q && (pcnt_q == presc_q);
  assign presc_rd = presc_q;

  always_comb begin
    presc_d = wr_ctrl ? PWDATA[CTRL_PRESC_MSB:CTRL_PRESC_LSB] : presc_q;
    pcnt_d  = (!en_q || wr_ctrl || tick) ? 8'd0 : pcnt_q + 8'd1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      presc_q <= 8'd0;
      pcnt_q  <= 8'd0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end
`else
  assign tick     = en_q;
  assign presc_rd = 8'd0;
`endif

  assign fire = tick && (value_q == '0);

  always_comb begin
    en_d       = en_q;
    periodic_d = periodic_q;
    ie_d       = ie_q;
    tf_d       = tf_q;
    perr_d     = perr_q;
    load_d     = load_q;
    value_d    = value_q;

    if (tick) begin
      if (value_q != '0) begin
        value_d = value_q - CNT_W'(1);
      end else if (periodic_q) begin
        value_d = load_q;
      end else begin
        en_d = 1'b0;
      end
    end

    // Bus writes are applied after the counter so they win over same-cycle hardware updates.
    if (wr_load) begin
      load_d  = PWDATA[CNT_W-1:0];
      value_d = PWDATA[CNT_W-1:0];
    end
    if (wr_ctrl) begin
      en_d       = PWDATA[CTRL_EN];
      periodic_d = PWDATA[CTRL_PERIODIC];
      ie_d       = PWDATA[CTRL_IE];
    end

    // W1C first, hardware set last: set wins on collision.
    if (wr_status && PWDATA[STATUS_TF])   tf_d   = 1'b0;
    if (wr_status && PWDATA[STATUS_PERR]) perr_d = 1'b0;
    if (fire)       tf_d   = 1'b1;
    if (perr_pulse) perr_d = 1'b1;
  end

  always_comb begin
    rd_mux = 32'd0;
    case (reg_sel)
      TMR_CTRL: begin
        rd_mux[CTRL_EN]                       = en_q;
        rd_mux[CTRL_PERIODIC]                 = periodic_q;
        rd_mux[CTRL_IE]                       = ie_q;
        rd_mux[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = presc_rd;
      end
      TMR_LOAD:  rd_mux[CNT_W-1:0] = load_q;
      TMR_VALUE: rd_mux[CNT_W-1:0] = value_q;
      default:   rd_mux            = status_word(tf_q, perr_q);
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      ie_q       <= 1'b0;
      tf_q       <= 1'b0;
      perr_q     <= 1'b0;
      load_q     <= RST_LOAD[CNT_W-1:0];
      value_q    <= RST_LOAD[CNT_W-1:0];
      PRDATA     <= 32'd0;
      IRQ        <= 1'b0;
    end else begin
      en_q       <= en_d;
      periodic_q <= periodic_d;
      ie_q       <= ie_d;
      tf_q       <= tf_d;
      perr_q     <= perr_d;
      load_q     <= load_d;
      value_q    <= value_d;
      // Snapshot at the read setup edge; held through access and any later writes.
      if (rd_en) PRDATA <= rd_mux;
      IRQ        <= tf_q & ie_q;
    end
  end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Self-checking bench for apb_timer_slave: directed scenarios plus random APB traffic vs a model.
module tb_apb_timer_slave;
  import apb_timer_slave_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = 32'd0, PWDATA = 32'd0;
  logic [31:0] PRDATA;
  logic        IRQ;

  apb_timer_slave dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .IRQ     (IRQ)
  );

  always #5 HCLK = ~HCLK;

`ifdef APB_TIMER_PRESCALER_EN
  localparam logic [7:0] PRESC_MASK = 8'hFF;
`else
  localparam logic [7:0] PRESC_MASK = 8'h00;
`endif

  int checks = 0;
  int failures = 0;
  bit mon_on = 1'b0;

  // Reference model state, advanced once per rising edge.
  bit          m_en, m_per, m_ie, m_tf, m_perr, m_irq;
  logic [31:0] m_load, m_value, m_prdata;
  logic [7:0]  m_presc, m_pc;

  // What the bench is doing on the bus this cycle.
  bit          b_wr = 1'b0, b_rd = 1'b0, b_perr = 1'b0;
  logic [1:0]  b_addr = 2'd0;
  logic [31:0] b_wdata = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {16'd0, m_presc, 5'd0, m_ie, m_per, m_en};
      2'd1:    return m_load;
      2'd2:    return m_value;
      default: return {30'd0, m_perr, m_tf};
    endcase
  endfunction

  initial begin : model
    bit          tick, fire, n_en, n_tf, n_perr;
    logic [31:0] n_val;
    logic [7:0]  n_pc;
    forever begin
      @(posedge HCLK or negedge HRESETn);
      if (!HRESETn) begin
        m_en = 0; m_per = 0; m_ie = 0; m_tf = 0; m_perr = 0; m_irq = 0;
        m_load = 32'd0; m_value = 32'd0; m_prdata = 32'd0; m_presc = 8'd0; m_pc = 8'd0;
      end else begin
        tick   = m_en && (m_pc == m_presc);
        fire   = tick && (m_value == 32'd0);
        n_en   = m_en;
        n_val  = m_value;
        n_tf   = m_tf;
        n_perr = m_perr;
        n_pc   = (!m_en || tick) ? 8'd0 : m_pc + 8'd1;
        if (tick) begin
          if (m_value != 32'd0) n_val = m_value - 32'd1;
          else if (m_per)       n_val = m_load;
          else                  n_en  = 1'b0;
        end
        if (b_rd) m_prdata = m_reg(b_addr);
        m_irq = m_tf && m_ie;
        if (b_wr) begin
          case (b_addr)
            2'd0: begin
              n_en = b_wdata[0]; m_per = b_wdata[1]; m_ie = b_wdata[2];
              m_presc = b_wdata[15:8] & PRESC_MASK; n_pc = 8'd0;
            end
            2'd1: begin m_load = b_wdata; n_val = b_wdata; end
            2'd3: begin
              if (b_wdata[0]) n_tf = 1'b0;
              if (b_wdata[1]) n_perr = 1'b0;
            end
            default: ;
          endcase
        end
        if (fire)   n_tf = 1'b1;
        if (b_perr) n_perr = 1'b1;
        m_en = n_en; m_value = n_val; m_tf = n_tf; m_perr = n_perr; m_pc = n_pc;
      end
    end
  end

  initial forever begin
    @(negedge HCLK);
    if (mon_on) begin
      check("irq_track", {31'd0, IRQ}, {31'd0, m_irq});
      check("prdata_track", PRDATA, m_prdata);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PWDATA = d;
    PADDR = ($urandom() & 32'hFFFF_FFF3) | {28'd0, a, 2'd0};
    @(negedge HCLK);
    PENABLE = 1; b_wr = 1; b_addr = a; b_wdata = d;
    @(negedge HCLK);
    PSEL = 0; PENABLE = 0; b_wr = 0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    PSEL = 1; PENABLE = 0; PWRITE = 0;
    PADDR = ($urandom() & 32'hFFFF_FFF3) | {28'd0, a, 2'd0};
    b_rd = 1; b_addr = a;
    @(negedge HCLK);
    b_rd = 0; PENABLE = 1; d = PRDATA;
    check("read_snapshot", d, m_prdata);
    @(negedge HCLK);
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic bus_perr(input logic wr);
    PSEL = 1; PENABLE = 1; PWRITE = wr; PADDR = 32'h4; PWDATA = 32'd9; b_perr = 1;
    @(negedge HCLK);
    PSEL = 0; PENABLE = 0; b_perr = 0;
  endtask

  initial begin
    logic [31:0] d, snap;
    HRESETn = 0;
    #10 HRESETn = 1;
    @(negedge HCLK);
    mon_on = 1;

    // Reset state
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      check($sformatf("reset_reg%0d", a), d, 32'd0);
    end
    check("reset_irq", {31'd0, IRQ}, 32'd0);

    // One-shot: 5..0, fire on the sixth tick, IRQ one cycle after TF
    bus_write(TMR_LOAD, 32'd5);
    bus_write(TMR_CTRL, 32'h5);
    repeat (5) @(negedge HCLK);
    check("oneshot_irq_pre", {31'd0, IRQ}, 32'd0);
    @(negedge HCLK);
    check("oneshot_irq_fire_cycle", {31'd0, IRQ}, 32'd0);
    @(negedge HCLK);
    check("oneshot_irq_set", {31'd0, IRQ}, 32'd1);
    bus_read(TMR_CTRL, d);   check("oneshot_en_cleared", d, 32'h4);
    bus_read(TMR_VALUE, d);  check("oneshot_value_zero", d, 32'd0);
    bus_read(TMR_STATUS, d); check("oneshot_tf", d, 32'h1);
    bus_write(TMR_STATUS, 32'h1);
    check("oneshot_irq_hold", {31'd0, IRQ}, 32'd1);
    @(negedge HCLK);
    check("oneshot_irq_clear", {31'd0, IRQ}, 32'd0);

    // Periodic reload 3,2,1,0,3
    bus_write(TMR_CTRL, 32'h0);
    bus_write(TMR_LOAD, 32'd3);
    bus_write(TMR_CTRL, 32'h3);
    bus_read(TMR_VALUE, d); check("periodic_v3", d, 32'd3);
    bus_read(TMR_VALUE, d); check("periodic_v1", d, 32'd1);
    bus_read(TMR_VALUE, d); check("periodic_reload", d, 32'd3);

    // Clear away from a fire edge clears TF
    for (int i = 0; i < 8 && m_value != 32'd2; i++) @(negedge HCLK);
    check("sync_value2", m_value, 32'd2);
    bus_write(TMR_STATUS, 32'h1);
    bus_read(TMR_STATUS, d); check("tf_cleared", d, 32'h0);
    // Clear colliding with a fire edge: set wins
    for (int i = 0; i < 8 && m_value != 32'd1; i++) @(negedge HCLK);
    check("sync_value1", m_value, 32'd1);
    bus_write(TMR_STATUS, 32'h1);
    bus_read(TMR_STATUS, d); check("tf_set_wins", d, 32'h1);

    // PRDATA survives an intervening write
    bus_read(TMR_VALUE, d);
    snap = m_prdata;
    bus_write(TMR_STATUS, 32'h0);
    check("prdata_after_write", PRDATA, snap);

    bus_write(TMR_CTRL, 32'h0);
    bus_write(TMR_STATUS, 32'h3);

    // Protocol error: enable without setup
    bus_perr(1'b1);
    bus_read(TMR_LOAD, d);   check("perr_load_kept", d, 32'd3);
    bus_read(TMR_STATUS, d); check("perr_status", d, 32'h2);
    bus_write(TMR_STATUS, 32'h2);
    bus_read(TMR_STATUS, d); check("perr_cleared", d, 32'h0);

`ifdef APB_TIMER_PRESCALER_EN
    bus_write(TMR_LOAD, 32'd2);
    bus_write(TMR_CTRL, 32'h0301);
    repeat (10) @(negedge HCLK);
    bus_read(TMR_STATUS, d); check("presc_tf_pre", d, 32'h0);
    bus_read(TMR_STATUS, d); check("presc_tf_12", d, 32'h1);
    bus_read(TMR_CTRL, d);   check("presc_ctrl", d, 32'h0300);
    bus_write(TMR_CTRL, 32'h0);
    bus_write(TMR_STATUS, 32'h1);
`else
    bus_write(TMR_CTRL, 32'h0300);
    bus_read(TMR_CTRL, d); check("presc_absent", d, 32'h0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        0, 1: bus_write(TMR_CTRL, $urandom() & 32'h0000_0107);
        2:    bus_write(TMR_LOAD, $urandom_range(0, 6));
        3:    bus_write(TMR_STATUS, $urandom_range(0, 3));
        4:    bus_write(TMR_VALUE, $urandom());
        5, 6: bus_read(2'($urandom_range(0, 3)), d);
        7:    bus_perr(1'($urandom_range(0, 1)));
        default: repeat ($urandom_range(0, 4)) @(negedge HCLK);
      endcase
    end

    // Reset during an access phase loses the write
    mon_on = 0;
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h4; PWDATA = 32'd77;
    @(negedge HCLK);
    PENABLE = 1;
    #1 HRESETn = 0; PSEL = 0; PENABLE = 0;
    #2 HRESETn = 1;
    @(negedge HCLK);
    mon_on = 1;
    bus_read(TMR_LOAD, d); check("midreset_load", d, 32'd0);
    bus_read(TMR_CTRL, d); check("midreset_ctrl", d, 32'd0);
    check("midreset_irq", {31'd0, IRQ}, 32'd0);

    mon_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_timer_slave.md
Name: apb_timer_slave

Overview:
- Zero-wait-state APB slave timer peripheral. It sits directly downstream of the AHB-to-APB bridge on one of its three PSEL lines.
- It consumes PADDR/PWDATA/PWRITE/PENABLE/PSELx from the bridge and returns PRDATA to it.
- It provides a programmable down-counter with one-shot or periodic reload and a level interrupt.
- It also tracks the APB phase sequence and flags protocol violations.

Parameters:
- CNT_W, 32, counter and LOAD register width (1..32); read data is zero-extended to 32 bits.
- RST_LOAD, 0, reset value of LOAD and VALUE.

Ports:
- HCLK  input  1  system clock; the APB side runs on the bridge clock.
- HRESETn  input  1  asynchronous active-low reset.
- PSEL  input  1  select for this slave (one bit of the bridge PSEL[2:0]).
- PENABLE  input  1  APB access-phase strobe.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  32  address; only PADDR[3:2] is decoded, all other bits ignored.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data, registered, valid throughout the access phase.
- IRQ  output  1  level interrupt = STATUS.TF & CTRL.IE, registered.

Behaviour:
- One clock; reset is asynchronous and active-low (HCLK, HRESETn). All flops clear immediately on HRESETn=0.
- Reset values: PRDATA=0, IRQ=0, CTRL=0, STATUS=0, LOAD=VALUE=RST_LOAD, FSM=IDLE.
- APB FSM states are IDLE, SETUP, ACCESS:
  - IDLE -> SETUP on PSEL & !PENABLE.
  - SETUP -> ACCESS on PSEL & PENABLE.
  - ACCESS -> SETUP on PSEL & !PENABLE (back-to-back transfer); ACCESS -> IDLE otherwise.
  - SETUP with !PSEL -> IDLE (aborted; no effect).
- Protocol error: PSEL & PENABLE while FSM is not SETUP.
  - The transfer is ignored: no write, PRDATA unchanged.
  - STATUS.PERR is set.
  - The FSM remains or returns to IDLE.
- Register map (offset = PADDR[3:2]*4):
  - 0x0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IE; RW; other bits read 0.
  - 0x4 LOAD: RW, CNT_W bits. Writing LOAD also loads VALUE in the same edge.
  - 0x8 VALUE: RO; writes ignored.
  - 0xC STATUS: bit0 TF (timer fired), bit1 PERR; write-1-to-clear.
- Writes commit on the rising edge where the FSM is in SETUP and PSEL & PENABLE & PWRITE is true (end of the access phase).
- Reads: on the edge where PSEL & !PENABLE & !PWRITE, PRDATA is loaded from the mux.
  - PRDATA therefore holds a snapshot taken at the setup phase and is stable for the whole access phase.
  - PRDATA holds its value until the next read setup. Write transfers do not disturb PRDATA.
- Counter: when EN=1, VALUE decrements by 1 every HCLK (or every prescaler tick when the optional feature is enabled).
  - On a tick with VALUE==0, TF is set.
  - If PERIODIC=1, VALUE<=LOAD.
  - If PERIODIC=0, VALUE stays 0 and EN is cleared by hardware.
  - There is no underflow wrap.
- Simultaneous events:
  - TF hardware set in the same cycle as a TF W1C: set wins.
  - LOAD write in the same cycle as a counter tick: the write wins, VALUE=new LOAD.
  - CTRL write clearing EN in the same cycle as the zero tick: TF is still set; the CTRL write value wins for EN.
  - PERR set in the same cycle as a PERR W1C: set wins.
- Setting EN with VALUE==0 fires TF on the next tick.
- IRQ updates one cycle after TF or IE changes.
- Reset mid-transfer: any write in progress is lost and the FSM returns to IDLE. The bridge must restart the transfer.

Optional Feature:
- Macro: APB_TIMER_PRESCALER_EN.
- Defined:
  - Register 0x4 is unchanged.
  - CTRL[15:8] holds PRESC (reset 0).
  - An 8-bit prescale counter generates a tick every PRESC+1 HCLK cycles while EN=1.
  - The prescale counter clears when EN=0 or when CTRL is written.
- Undefined:
  - CTRL[15:8] reads 0 and writes to it are ignored.
  - The tick is asserted every cycle.

Decomposition:
- Shared package/header holds the register offset constants (TMR_CTRL=2'd0, TMR_LOAD=2'd1, TMR_VALUE=2'd2, TMR_STATUS=2'd3) and the CTRL/STATUS bit-index constants.
- Shared package/header also holds the FSM state encodings (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2).
- One natural sub-module is apb_slave_if: the phase FSM plus PERR detection. It outputs wr_en, rd_en, reg_sel[1:0] and perr_pulse.
- Timer and register logic stay in the top module.

Test Plan:
- Reset: HRESETn=0 for 10 ns, then read all four registers -> CTRL=0, LOAD=VALUE=0, STATUS=0, IRQ=0.
- One-shot: write LOAD=5, write CTRL=0x5 (EN|IE) -> VALUE counts 5..0, TF=1 and IRQ=1 one cycle later, EN reads 0. Write STATUS=1 -> TF=0 and IRQ=0 next cycle.
- Periodic: LOAD=3, CTRL=0x3 -> TF sets every 4 cycles and VALUE sequence is 3,2,1,0,3. A TF clear colliding with a fire cycle leaves TF=1.
- Read timing: a read of VALUE while counting returns the value sampled at the setup edge, stable across the access phase. The PRDATA seen by the bridge is unchanged across an intervening write.
- Protocol error: drive PSEL=1, PENABLE=1 without a setup phase, PWRITE=1, PADDR=0x4, PWDATA=9 -> LOAD unchanged, STATUS=0x2. Write STATUS=2 -> STATUS reads 0.
- Prescaler (APB_TIMER_PRESCALER_EN): CTRL=0x0301 with LOAD=2 -> VALUE decrements every 4 HCLK and TF sets after 12 cycles.
